// File: rtl/pll_reconfig_ctrl_if.sv
// Avalon-MM write-only management port between the reconfig sequencer and
// the PLL reconfiguration block.
interface pll_reconfig_ctrl_if;
   logic        mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_waitrequest;

   modport master (
      output mgmt_write,
      output mgmt_address,
      output mgmt_writedata,
      input  mgmt_waitrequest
   );

   modport slave (
      input  mgmt_write,
      input  mgmt_address,
      input  mgmt_writedata,
      output mgmt_waitrequest
   );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// Switches clk_sys between native and 60Hz-overclocked timing by replaying the
// PLL reconfig write sequence (mode, fractional M, start) after a filtered select change.
module pll_reconfig_ctrl #(
   parameter logic [31:0] FRAC_NATIVE   = 32'd2748778984,
   parameter logic [31:0] FRAC_FAST     = 32'd3221912667,
   parameter int          STABLE_CYCLES = 16,
   parameter int          LOCK_TIMEOUT  = 1048576,
   parameter int          CNT_W         = 21
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                speed_sel,
   input  logic                pll_locked,
   pll_reconfig_ctrl_if.master mgmt,
   output logic                busy,
   output logic                done,
   output logic                lock_err,
   output logic                applied_mode
);
   localparam int               FLT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [FLT_W-1:0] FLT_MAX    = FLT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_MIN   = CNT_W'(4);
   localparam logic [CNT_W-1:0] LOCK_MAX   = CNT_W'(LOCK_TIMEOUT);
   localparam logic [5:0]       ADDR_MODE  = 6'd0;
   localparam logic [5:0]       ADDR_FRAC  = 6'd7;
   localparam logic [5:0]       ADDR_START = 6'd2;

   typedef enum logic [2:0] {IDLE, W_MODE, W_FRAC, W_START, WAIT_LOCK} state_t;

   state_t           state;
   state_t           wr_next;
   logic [1:0]       sel_sync;
   logic [1:0]       lock_sync;
   logic             sel_s;
   logic             lock_s;
   logic             sel_q;
   logic [FLT_W-1:0] flt_cnt;
   logic [CNT_W-1:0] lock_cnt;
   logic             target_r;
   logic             init_pending;
   logic             sel_stable;
   logic             accept;
   logic             xfer_done;
   logic [5:0]       wr_addr;
   logic [31:0]      wr_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_sync  <= '0;
         lock_sync <= '0;
      end else begin
         sel_sync  <= {sel_sync[0], speed_sel};
         lock_sync <= {lock_sync[0], pll_locked};
      end
   end

   assign sel_s  = sel_sync[1];
   assign lock_s = lock_sync[1];

   // Stability counter keeps running while busy so a request can be taken
   // the moment the FSM returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q   <= 1'b0;
         flt_cnt <= '0;
      end else begin
         sel_q <= sel_s;
         if (sel_s != sel_q)
            flt_cnt <= '0;
         else if (flt_cnt != FLT_MAX)
            flt_cnt <= flt_cnt + FLT_W'(1);
      end
   end

   // The edge cycle itself must not look stable while the counter still holds the old run.
   assign sel_stable = (flt_cnt == FLT_MAX) && (sel_s == sel_q);
   assign accept     = (state == IDLE) && sel_stable && (init_pending || (sel_s != target_r));
   assign xfer_done  = mgmt.mgmt_write && !mgmt.mgmt_waitrequest;

   always_comb begin
      wr_addr = ADDR_MODE;
      wr_data = '0;
      wr_next = W_FRAC;
      case (state)
         W_FRAC: begin
            wr_addr = ADDR_FRAC;
            wr_data = target_r ? FRAC_FAST : FRAC_NATIVE;
            wr_next = W_START;
         end
         W_START: begin
            wr_addr = ADDR_START;
            wr_next = WAIT_LOCK;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         mgmt.mgmt_write     <= 1'b0;
         mgmt.mgmt_address   <= '0;
         mgmt.mgmt_writedata <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         lock_err            <= 1'b0;
         applied_mode        <= 1'b0;
         target_r            <= 1'b0;
         init_pending        <= 1'b1;
         lock_cnt            <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  target_r     <= sel_s;
                  init_pending <= 1'b0;
                  lock_err     <= 1'b0;
                  busy         <= 1'b1;
                  state        <= W_MODE;
               end
            end
            W_MODE, W_FRAC, W_START: begin
               // Strobe rises one cycle into the state and drops the cycle after
               // acceptance, which also guarantees an idle gap between writes.
               if (!mgmt.mgmt_write) begin
                  mgmt.mgmt_write     <= 1'b1;
                  mgmt.mgmt_address   <= wr_addr;
                  mgmt.mgmt_writedata <= wr_data;
               end else if (xfer_done) begin
                  mgmt.mgmt_write <= 1'b0;
                  lock_cnt        <= '0;
                  state           <= wr_next;
               end
            end
            WAIT_LOCK: begin
               // lock_s is not trusted for the first cycles: it may still show the
               // pre-reconfig lock through the synchroniser.
               if (lock_s && (lock_cnt >= LOCK_MIN)) begin
                  applied_mode <= target_r;
                  done         <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else if (lock_cnt == LOCK_MAX) begin
                  lock_err <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  lock_cnt <= lock_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_hold: assert property (@(posedge clk) disable iff (reset)
      (mgmt.mgmt_write && mgmt.mgmt_waitrequest) |=>
         (mgmt.mgmt_write && $stable(mgmt.mgmt_address) && $stable(mgmt.mgmt_writedata)));

   a_gap: assert property (@(posedge clk) disable iff (reset)
      xfer_done |=> !mgmt.mgmt_write);
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Randomised bench for pll_reconfig_ctrl: observed Avalon transfers, done/lock_err
// and applied_mode are scored against a request-level model of the sequencer.
module tb_pll_reconfig_ctrl;
   localparam logic [31:0] F_NAT  = 32'd2748778984;
   localparam logic [31:0] F_FAST = 32'd3221912667;
   localparam int          STAB   = 16;
   localparam int          LTO    = 1000;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
      int          c;
      int          len;
   } xfer_t;

   logic clk = 1'b0;
   logic reset;
   logic speed_sel;
   logic pll_locked;
   logic busy;
   logic done;
   logic lock_err;
   logic applied_mode;

   pll_reconfig_ctrl_if mgmt ();

   pll_reconfig_ctrl #(
      .FRAC_NATIVE  (F_NAT),
      .FRAC_FAST    (F_FAST),
      .STABLE_CYCLES(STAB),
      .LOCK_TIMEOUT (LTO),
      .CNT_W        (21)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .speed_sel   (speed_sel),
      .pll_locked  (pll_locked),
      .mgmt        (mgmt),
      .busy        (busy),
      .done        (done),
      .lock_err    (lock_err),
      .applied_mode(applied_mode)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc   = 0;
   xfer_t xq[$];
   int    n_done = 0;
   int    done_c = 0;
   int    err_c  = 0;
   int    wmode  = 0;
   int    st     = 0;

   // request-level model state
   bit    m_init;
   logic  m_target;
   logic  m_applied;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // waitrequest modes: 0 never, 1 random, 2 stall addr-7 write for 7 cycles, 3 stall addr 7 forever
   task automatic drive_wait();
      case (wmode)
         0: mgmt.mgmt_waitrequest = 1'b0;
         1: mgmt.mgmt_waitrequest = ($urandom_range(0, 2) == 0);
         2: begin
            if (mgmt.mgmt_write && mgmt.mgmt_address == 6'd7 && st < 7) begin
               mgmt.mgmt_waitrequest = 1'b1;
               st++;
            end else begin
               mgmt.mgmt_waitrequest = 1'b0;
               if (!mgmt.mgmt_write) st = 0;
            end
         end
         default: mgmt.mgmt_waitrequest = mgmt.mgmt_write && (mgmt.mgmt_address == 6'd7);
      endcase
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         drive_wait();
      end
   endtask

   // monitor: protocol checks and transfer capture, sampled mid-cycle
   logic        p_w = 1'b0, p_wait = 1'b0, p_rst = 1'b1, p_err = 1'b0;
   logic [5:0]  p_a = '0;
   logic [31:0] p_d = '0;
   int          run_len = 0;

   always @(negedge clk) begin
      if (!p_rst && p_w && p_wait) begin
         chk("hold_write", mgmt.mgmt_write, 1);
         chk("hold_addr", mgmt.mgmt_address, p_a);
         chk("hold_data", mgmt.mgmt_writedata, p_d);
      end
      if (!p_rst && p_w && !p_wait)
         chk("idle_gap", mgmt.mgmt_write, 0);
      if (mgmt.mgmt_write) run_len++;
      if (mgmt.mgmt_write && !mgmt.mgmt_waitrequest && !reset)
         xq.push_back('{a: mgmt.mgmt_address, d: mgmt.mgmt_writedata, c: cyc, len: run_len});
      if (!mgmt.mgmt_write || !mgmt.mgmt_waitrequest) run_len = 0;
      if (done) begin
         n_done++;
         done_c = cyc;
      end
      if (lock_err && !p_err) err_c = cyc;
      p_w    = mgmt.mgmt_write;
      p_wait = mgmt.mgmt_waitrequest;
      p_rst  = reset;
      p_err  = lock_err;
      p_a    = mgmt.mgmt_address;
      p_d    = mgmt.mgmt_writedata;
   end

   task automatic run_req(input logic s, input int drop, input bit tmo, input int wm);
      bit          exp_seq;
      int          t0;
      int          k;
      logic [5:0]  ea[3];
      logic [31:0] ed[3];
      exp_seq = m_init || (s != m_target);
      ea[0] = 6'd0; ea[1] = 6'd7; ea[2] = 6'd2;
      ed[0] = '0;   ed[1] = s ? F_FAST : F_NAT; ed[2] = '0;
      wmode = wm;
      xq.delete();
      n_done = 0;
      speed_sel = s;
      t0 = cyc;
      if (!exp_seq) begin
         tick(STAB + 20);
         chk("same_sel_no_write", xq.size(), 0);
         chk("same_sel_no_done", n_done, 0);
         return;
      end
      k = 0;
      while (xq.size() < 3 && k < 400) begin
         tick();
         k++;
      end
      chk("start_write_seen", xq.size() >= 3, 1);
      chk("busy_during_seq", busy, 1);
      chk("lock_err_cleared", lock_err, 0);
      if (tmo || drop > 0) pll_locked = 1'b0;
      if (!tmo) begin
         tick(drop);
         pll_locked = 1'b1;
      end
      k = 0;
      while (n_done == 0 && !lock_err && k < (tmo ? LTO + 50 : 60)) begin
         tick();
         k++;
      end
      tick(2);
      pll_locked = 1'b1;
      chk("write_count", xq.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < xq.size()) begin
            chk("write_addr", xq[i].a, ea[i]);
            chk("write_data", xq[i].d, ed[i]);
         end
      end
      if (xq.size() >= 3) begin
         if (wm == 0) begin
            chk("write_spacing", xq[2].c - xq[0].c, 4);
            chk("accept_latency", (xq[0].c - t0 >= STAB) && (xq[0].c - t0 <= STAB + 10), 1);
            chk("single_cycle_write", xq[1].len, 1);
         end
         if (wm == 2) chk("stalled_write_len", xq[1].len, 8);
         if (tmo)
            chk("timeout_window", (err_c - xq[2].c >= LTO) && (err_c - xq[2].c <= LTO + 10), 1);
         else
            chk("done_latency", (done_c - xq[2].c >= 5) && (done_c - xq[2].c <= drop + 12), 1);
      end
      m_init   = 1'b0;
      m_target = s;
      if (!tmo) m_applied = s;
      chk("done_pulses", n_done, tmo ? 0 : 1);
      chk("lock_err", lock_err, tmo);
      chk("busy_after", busy, 0);
      chk("applied_mode", applied_mode, m_applied);
      tick(STAB + 10);
      chk("no_extra_writes", xq.size(), 3);
   endtask

   task automatic glitch(input int g);
      wmode = 0;
      xq.delete();
      speed_sel = ~m_target;
      tick(g);
      speed_sel = m_target;
      tick(STAB + 20);
      chk("glitch_no_write", xq.size(), 0);
      chk("glitch_mode", applied_mode, m_applied);
   endtask

   initial begin
      int k;
      reset = 1'b1;
      speed_sel = 1'b0;
      pll_locked = 1'b1;
      mgmt.mgmt_waitrequest = 1'b0;
      m_init = 1'b1;
      m_target = 1'b0;
      m_applied = 1'b0;
      tick(3);
      chk("rst_write", mgmt.mgmt_write, 0);
      chk("rst_addr", mgmt.mgmt_address, 0);
      chk("rst_data", mgmt.mgmt_writedata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lock_err", lock_err, 0);
      chk("rst_mode", applied_mode, 0);
      reset = 1'b0;

      run_req(1'b0, 0, 1'b0, 0);
      run_req(1'b1, 3, 1'b0, 0);
      glitch(10);
      run_req(1'b0, 2, 1'b0, 2);
      run_req(1'b1, 0, 1'b1, 0);
      run_req(1'b0, 1, 1'b0, 0);

      for (int i = 0; i < 14; i++) begin
         if ($urandom_range(0, 3) == 0)
            glitch($urandom_range(1, 12));
         else
            run_req(1'(($urandom_range(0, 1))), $urandom_range(0, 8), 1'b0, $urandom_range(0, 1));
      end

      // reset while the fractional write is stalled
      wmode = 3;
      xq.delete();
      speed_sel = ~m_target;
      k = 0;
      while (!(mgmt.mgmt_write && mgmt.mgmt_address == 6'd7) && k < 200) begin
         tick();
         k++;
      end
      chk("frac_write_reached", mgmt.mgmt_write && (mgmt.mgmt_address == 6'd7), 1);
      reset = 1'b1;
      tick();
      chk("rst_mid_write", mgmt.mgmt_write, 0);
      chk("rst_mid_busy", busy, 0);
      reset = 1'b0;
      wmode = 0;
      m_init = 1'b1;
      m_target = 1'b0;
      m_applied = 1'b0;
      chk("rst_mid_mode", applied_mode, 0);
      run_req(speed_sel, 0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequences Avalon-MM writes to the PLL reconfiguration block, switching clk_sys between the native pixel rate and the 60Hz-overclocked rate on request of an OSD status bit. It filters the asynchronous select, then issues the fixed register write sequence: mode, fractional M, start. It then waits for the PLL to relock and reports completion, lock timeout and the applied mode. It sits beside pll_cfg on the management clock.

Parameters:
FRAC_NATIVE, 32'd2748778984, M-counter fractional word for native timing
FRAC_FAST, 32'd3221912667, M-counter fractional word for 60Hz timing
STABLE_CYCLES, 16, cycles the synchronised select must hold before acceptance (>=1)
LOCK_TIMEOUT, 1048576, max cycles to wait for locked after start write
CNT_W, 21, width of the stability/timeout counter (must hold LOCK_TIMEOUT)

Ports:
clk  in  1  management clock (CLK_50M domain)
reset  in  1  synchronous, active-high reset
speed_sel  in  1  asynchronous request: 0 native, 1 fast
pll_locked  in  1  PLL lock, asynchronous
mgmt_waitrequest  in  1  reconfig block stall
mgmt_write  out  1  write strobe
mgmt_address  out  6  register address
mgmt_writedata  out  32  write data
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on successful relock
lock_err  out  1  sticky: relock timed out; cleared by the next accepted request or by reset
applied_mode  out  1  mode of last completed sequence

Behaviour:
- Synchronisation: speed_sel and pll_locked each pass through a 2-flop synchroniser. All logic below uses the synchronised copies sel_s and lock_s.
- Filter: the counter restarts whenever sel_s changes. A request is accepted when sel_s has been stable for STABLE_CYCLES consecutive cycles and differs from target_r, or when init_pending is set.
- Reset values: mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, done=0, lock_err=0, applied_mode=0, target_r=0, init_pending=1, state=IDLE.
- init_pending: after reset, the first filtered value (either polarity) always runs one sequence. This re-establishes a known PLL state if reset hits mid-sequence.
- States:
  - IDLE: on acceptance, latch target_r=sel_s, clear init_pending and lock_err, set busy, go to W_MODE.
  - W_MODE: drive addr 0, data 0.
  - W_FRAC: drive addr 7, data = target_r ? FRAC_FAST : FRAC_NATIVE.
  - W_START: drive addr 2, data 0.
  - WAIT_LOCK: load the counter with 0.
    - When lock_s=1 and the counter is >=4 (ignores stale lock during relock): applied_mode<=target_r, done pulses 1 cycle, busy<=0, go to IDLE.
    - When the counter reaches LOCK_TIMEOUT: lock_err<=1, busy<=0, applied_mode unchanged, go to IDLE.
- Write handshake (Avalon):
  - mgmt_write, address and data are registered and asserted on the cycle after entering a W_* state.
  - They stay stable while mgmt_waitrequest=1.
  - A transfer completes on a cycle with mgmt_write=1 and mgmt_waitrequest=0. On the next cycle mgmt_write=0 and the FSM advances.
  - There is exactly one accepted write per W_* state. Back-to-back writes have at least 1 idle cycle between them.
- Select change while busy: the sequence completes unchanged. The filter keeps running, and a new request is evaluated in IDLE against target_r. A select that toggles and returns before IDLE causes no extra sequence.
- Latency with zero waitrequest: first mgmt_write on cycle 2 after acceptance, start write on cycle 6, done at the earliest 5 cycles after the start write completes.
- Reset mid-operation: the FSM returns to IDLE within 1 cycle and mgmt_write drops immediately, without waiting on waitrequest. init_pending forces a full resequence.
- pll_locked is ignored outside WAIT_LOCK.

Test Plan:
- Reset, speed_sel=0 stable, waitrequest=0, locked=1:
  - After sync+16 cycles, writes (0,0), (7,2748778984), (2,0) appear in order.
  - done pulses once; applied_mode=0; no further writes.
- speed_sel 0->1 held:
  - Same sequence with data 3221912667; locked dropped 3 cycles and then restored gives done and applied_mode=1.
- speed_sel glitch 1 for 10 cycles and back to 0 (STABLE_CYCLES=16): no mgmt_write issued.
- waitrequest held 1 for 7 cycles during the addr 7 write:
  - mgmt_write, address and data stay constant for 8 cycles.
  - Exactly one transfer completes; the FSM then proceeds to addr 2.
- locked held 0 with LOCK_TIMEOUT=1000: lock_err=1 after 1000 cycles, busy=0, applied_mode unchanged. The next toggle clears lock_err.
- reset asserted during W_FRAC with waitrequest=1: mgmt_write is 0 on the next cycle. After reset the full three-write sequence reruns for the current select.
